// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: size codes and lane helpers shared by the MEM stage and its data RAM.
package mem_stage_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  localparam int MAX_BYTES = 32;
  localparam int MAX_DATA  = 8 * MAX_BYTES;
  function automatic int nb_lane(input int nb_data);
    return $clog2(nb_data / 8);
  endfunction
  function automatic logic [MAX_BYTES-1:0] byte_en(input logic [1:0] size, input int lane, input int nb_bytes);
    return size == SZ_BYTE ? MAX_BYTES'(1) << lane :
           size == SZ_HALF ? MAX_BYTES'(3) << lane :
           size == SZ_WORD ? {MAX_BYTES{1'b1}} >> (MAX_BYTES - nb_bytes) : '0;
  endfunction
  // Shift the addressed lane down to bit 0, then extend to the full width.
  function automatic logic [MAX_DATA-1:0] load_ext(input logic [MAX_DATA-1:0] word, input logic [1:0] size,
                                                   input int lane, input logic uns);
    logic [MAX_DATA-1:0] sh;
    sh = word >> (8 * lane);
    return size == SZ_BYTE ? {{(MAX_DATA-8){~uns & sh[7]}}, sh[7:0]} :
           size == SZ_HALF ? {{(MAX_DATA-16){~uns & sh[15]}}, sh[15:0]} : sh;
  endfunction
endpackage

// File: rtl/memory_access_stage_mem.sv
// be_data_memory: byte-enabled word RAM with a combinational access port and a debug read port.
module be_data_memory
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10
) (
  input  logic                 i_clock,
  input  logic [NB_DATA/8-1:0] i_we,
  input  logic [NB_ADDR-1:0]   i_addr,
  input  logic [NB_DATA-1:0]   i_wdata,
  output logic [NB_DATA-1:0]   o_rdata,
  input  logic [NB_ADDR-1:0]   i_dbg_addr,
  output logic [NB_DATA-1:0]   o_dbg_rdata
);
  logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
  always_ff @(posedge i_clock)
    for (int b = 0; b < NB_DATA/8; b++)
      if (i_we[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
  assign o_rdata     = mem_q[i_addr];
  assign o_dbg_rdata = mem_q[i_dbg_addr];
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM pipeline stage with sized loads/stores, misalignment detection and MEM/WB register.
module memory_access_stage
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_REG  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic [NB_DATA-1:0] i_rf_data,
  input  logic [NB_REG-1:0]  i_rd_addr,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data_ltchd,
  output logic [NB_DATA-1:0] o_alu_result_ltchd,
  output logic [NB_REG-1:0]  o_rd_addr,
  output logic               o_reg_write,
  output logic               o_mem_to_reg,
  output logic               o_misalign,
  output logic [NB_DATA-1:0] o_dbg_data
);
  localparam int NB_LANE  = nb_lane(NB_DATA);
  localparam int NB_BYTES = NB_DATA / 8;
  logic [NB_ADDR-1:0]   widx;
  logic [NB_LANE-1:0]   lane;
  logic                 mis, op_en, st_en, ld_ok;
  logic [MAX_BYTES-1:0] be_full;
  logic [NB_BYTES-1:0]  we;
  logic [NB_DATA-1:0]   wdata, rdata, dbg_rdata, ld;
  logic [MAX_DATA-1:0]  ld_full;
  logic                 unused_bits;
  logic                 valid_d, valid_q, reg_write_d, reg_write_q, mem_to_reg_d, mem_to_reg_q, mis_d, mis_q;
  logic [NB_DATA-1:0]   data_d, data_q, alu_d, alu_q, dbg_q;
  logic [NB_REG-1:0]    rd_d, rd_q;
  assign widx  = i_alu_result[NB_ADDR+NB_LANE-1:NB_LANE];
  assign lane  = i_alu_result[NB_LANE-1:0];
  assign mis   = (i_mem_read | i_mem_write) &
                 ((i_size == SZ_HALF & lane[0]) | (i_size == SZ_WORD & |lane) | i_size == SZ_ILL);
  assign op_en = i_valid & ~i_stall & ~i_flush & ~i_reset;
  assign st_en = op_en & i_mem_write & ~mis;
  assign ld_ok = i_valid & i_mem_read & ~i_mem_write & ~mis;
  assign be_full = byte_en(i_size, int'(lane), NB_BYTES);
  assign we      = st_en ? be_full[NB_BYTES-1:0] : '0;
  // Replicate the right-aligned store data so every candidate lane carries it.
  always_comb begin
    wdata = '0;
    for (int b = 0; b < NB_BYTES; b++)
      wdata[8*b +: 8] = i_size == SZ_BYTE ? i_rf_data[7:0] :
                        i_size == SZ_HALF ? i_rf_data[8*(b%2) +: 8] : i_rf_data[8*b +: 8];
  end
  be_data_memory #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_mem (
    .i_clock    (i_clock),
    .i_we       (we),
    .i_addr     (widx),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_rdata(dbg_rdata)
  );
  assign ld_full = load_ext(MAX_DATA'(rdata), i_size, int'(lane), i_unsigned);
  assign ld      = ld_full[NB_DATA-1:0];
  assign unused_bits = ^{i_alu_result[NB_DATA-1:NB_ADDR+NB_LANE], ld_full[MAX_DATA-1:NB_DATA],
                         be_full[MAX_BYTES-1:NB_BYTES]};
  always_comb begin
    valid_d      = i_valid;
    data_d       = ld_ok ? ld : '0;
    alu_d        = i_alu_result;
    rd_d         = i_rd_addr;
    reg_write_d  = i_valid & i_reg_write & ~mis;
    mem_to_reg_d = i_mem_to_reg;
    mis_d        = i_valid & mis;
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset || i_flush) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      alu_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mis_q        <= 1'b0;
    end else if (!i_stall) begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      alu_q        <= alu_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mis_q        <= mis_d;
    end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) dbg_q <= '0;
    else         dbg_q <= dbg_rdata;
  assign o_valid            = valid_q;
  assign o_data_ltchd       = data_q;
  assign o_alu_result_ltchd = alu_q;
  assign o_rd_addr          = rd_q;
  assign o_reg_write        = reg_write_q;
  assign o_mem_to_reg       = mem_to_reg_q;
  assign o_misalign         = mis_q;
  assign o_dbg_data         = dbg_q;
endmodule
